// File: rtl/apb_slave_bank.sv
// -----------------------------------------------------------------------------
// apb_slave_bank
//   APB completer bank with NUM_SLAVES register-file slaves. Each slave holds
//   DEPTH words of DATA_W bits. Every transfer goes through the states
//   IDLE -> SETUP -> ACCESS. The bank inserts WAIT_CYCLES wait states before
//   it raises Pready. Word addresses at or above DEPTH are out of range.
//
//   Optional feature macro: APB_SLVERR_EN
//     defined   : an out-of-range index or a multi-hot Pselx raises Pslverr
//                 in the Pready cycle. Such a write is dropped and such a
//                 read returns 0.
//     undefined : Pslverr stays 0. Out-of-range writes are dropped and
//                 out-of-range reads return 0. A multi-hot Pselx uses the
//                 lowest selected slave.
//
// Ports
//   Pclk     in   APB clock (rising edge)
//   Preset   in   asynchronous active-high reset
//   Pselx    in   [NUM_SLAVES] one-hot slave select (lowest set bit wins)
//   Penable  in   access-phase strobe
//   Pwrite   in   1 = write, 0 = read
//   Paddr    in   [ADDR_W] byte address, bits [1:0] ignored
//   Pwdata   in   [DATA_W] write data
//   Prdata   out  [DATA_W] registered read data, non-zero only in a read's Pready cycle
//   Pready   out  registered transfer complete
//   Pslverr  out  registered error flag, meaningful only with Pready
// -----------------------------------------------------------------------------
module apb_slave_bank #(
    parameter int NUM_SLAVES  = 3,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  Pclk,
    input  logic                  Preset,
    input  logic [NUM_SLAVES-1:0] Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [ADDR_W-1:0]     Paddr,
    input  logic [DATA_W-1:0]     Pwdata,
    output logic [DATA_W-1:0]     Prdata,
    output logic                  Pready,
    output logic                  Pslverr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLV_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // The wait counter is 4 bits wide, so WAIT_CYCLES must stay in 0..15.
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [NUM_SLAVES][DEPTH];

    logic              sel;
    logic [SLV_W-1:0]  slv;
    logic [IDX_W-1:0]  widx;
    logic              in_range;
    logic              xfer_err;
    logic              ok;
    logic              wr_en;
    logic [DATA_W-1:0] cpl_rdata;
    logic              unused_addr_lsb;

    function automatic logic [SLV_W-1:0] lowest_sel(input logic [NUM_SLAVES-1:0] s);
        lowest_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (s[i]) lowest_sel = SLV_W'(i);
        end
    endfunction

    assign sel             = |Pselx;
    assign slv             = lowest_sel(Pselx);
    assign widx            = Paddr[2 +: IDX_W];
    assign unused_addr_lsb = ^Paddr[1:0];

    // Compare the whole word index. The upper bits must not alias back
    // into the array.
    assign in_range = {2'b00, Paddr[ADDR_W-1:2]} < ADDR_W'(DEPTH);

`ifdef APB_SLVERR_EN
    logic multi_hot;
    assign multi_hot = (Pselx & (Pselx - NUM_SLAVES'(1))) != '0;
    assign xfer_err  = !in_range || multi_hot;
`else
    assign xfer_err  = 1'b0;
`endif

    assign ok        = in_range && !xfer_err;
    assign cpl_rdata = (!Pwrite && ok) ? mem_q[slv][widx] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                rdy_d   = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
                // sel together with Penable in IDLE is a protocol violation and is ignored.
                if (sel && !Penable) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = WAIT_INIT;
                rdy_d   = (WAIT_CYCLES == 0);
                if (WAIT_CYCLES == 0) begin
                    rdata_d = cpl_rdata;
                    err_d   = xfer_err;
                end
            end
            ACCESS: begin
                if (!rdy_q) begin
                    if (!sel) begin
                        // The master abandoned the transfer, so nothing commits.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            rdy_d   = 1'b1;
                            rdata_d = cpl_rdata;
                            err_d   = xfer_err;
                        end
                    end
                end else begin
                    rdy_d   = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (Penable) begin
                        wr_en   = sel && Pwrite && ok;
                        state_d = (sel && !Penable) ? SETUP : IDLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                rdy_d   = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    mem_q[s][w] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[slv][widx] <= Pwdata;
        end
    end

    assign Prdata  = rdata_q;
    assign Pready  = rdy_q;
    assign Pslverr = err_q;

endmodule

// File: tb/tb_apb_slave_bank.sv
module tb_apb_slave_bank;
    localparam int NS    = 3;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
`ifdef APB_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] psel [3];
    logic          en, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata [3];
    logic          pready [3];
    logic          pslverr [3];

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model [3][NS][DEPTH];

    always #5 clk = ~clk;

    // Three banks: instance 0 has WAIT_CYCLES=0, instance 1 has 1, instance 2 has 3.
    apb_slave_bank #(.NUM_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .Pclk(clk), .Preset(rst), .Pselx(psel[0]), .Penable(en), .Pwrite(wr), .Paddr(addr),
        .Pwdata(wdata), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));
    apb_slave_bank #(.NUM_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (
        .Pclk(clk), .Preset(rst), .Pselx(psel[1]), .Penable(en), .Pwrite(wr), .Paddr(addr),
        .Pwdata(wdata), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));
    apb_slave_bank #(.NUM_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
        .Pclk(clk), .Preset(rst), .Pselx(psel[2]), .Penable(en), .Pwrite(wr), .Paddr(addr),
        .Pwdata(wdata), .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]));

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [NS-1:0] s);
        for (int i = 0; i < NS; i++) if (s[i]) return i;
        return 0;
    endfunction

    // Reference behaviour: the lowest selected slave is used. An index at or
    // above DEPTH is out of range. Errors are reported only with the feature on.
    task automatic model_apply(input int k, input logic [NS-1:0] s, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] exp_rd, output logic exp_e);
        longint unsigned idx = longint'(a) >> 2;
        bit oor   = idx >= DEPTH;
        bit multi = $countones(s) > 1;
        bit good;
        exp_e  = SLVERR_EN && (oor || multi);
        good   = !oor && !exp_e;
        exp_rd = '0;
        if (good && w)  model[k][lowest(s)][int'(idx)] = d;
        if (good && !w) exp_rd = model[k][lowest(s)][int'(idx)];
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < NS; s++)
                for (int i = 0; i < DEPTH; i++) model[k][s][i] = '0;
    endtask

    task automatic drive_idle();
        for (int j = 0; j < 3; j++) psel[j] = '0;
        en = 1'b0;
        wr = 1'b0;
    endtask

    // Run one APB transfer on bank k. Return the data and error seen in the
    // Pready cycle and the ACCESS cycle number in which Pready rose.
    task automatic xfer(input int k, input logic [NS-1:0] s, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int n);
        @(negedge clk);
        check("idle_pready", 32'(pready[k]), 32'd0);
        check("idle_prdata", prdata[k], 32'd0);
        drive_idle();
        psel[k] = s; wr = w; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!pready[k]) check("wait_prdata", prdata[k], 32'd0);
        end while (!pready[k] && n < 32);
        rd = prdata[k];
        e  = pslverr[k];
    endtask

    task automatic bus_idle();
        @(negedge clk);
        drive_idle();
    endtask

    typedef struct {
        int            k;
        logic [NS-1:0] s;
        logic          w;
        logic [31:0]   a;
        logic [31:0]   d;
        logic [31:0]   rd;
        logic          e;
    } vec_t;

    vec_t          tbl [$];
    logic [31:0]   rd, exp_rd;
    logic          e, exp_e;
    int            n;

    initial begin
        clear_model();
        rst = 1'b1;
        drive_idle();
        addr = '0;
        wdata = '0;

        // Reset state of all three banks.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_pready", 32'(pready[k]), 32'd0);
            check("rst_prdata", prdata[k], 32'd0);
            check("rst_pslverr", 32'(pslverr[k]), 32'd0);
        end
        rst = 1'b0;

        // Reset in the Pready cycle of a write aborts it before the write commits.
        @(negedge clk);
        psel[1] = 3'b001; en = 1'b0; wr = 1'b1; addr = 32'h4; wdata = 32'hCAFE_F00D;
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_pready_before", 32'(pready[1]), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_pready", 32'(pready[1]), 32'd0);
        check("midrst_prdata", prdata[1], 32'd0);
        check("midrst_pslverr", 32'(pslverr[1]), 32'd0);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        clear_model();
        xfer(1, 3'b001, 1'b0, 32'h4, 32'h0, rd, e, n);
        check("midrst_readback", rd, 32'd0);
        check("midrst_lat", 32'(n), 32'd2);

        // Directed vectors. The rows run back to back with Pselx held active between transfers.
        tbl.push_back('{1, 3'b100, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{1, 3'b100, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 3'b010, 1'b1, 32'h00, 32'h11,       32'h0,        1'b0});
        tbl.push_back('{0, 3'b010, 1'b1, 32'h04, 32'h22,       32'h0,        1'b0});
        tbl.push_back('{0, 3'b010, 1'b0, 32'h00, 32'h0,        32'h11,       1'b0});
        tbl.push_back('{0, 3'b010, 1'b0, 32'h04, 32'h0,        32'h22,       1'b0});
        tbl.push_back('{1, 3'b001, 1'b1, 32'h0C, 32'hA5,       32'h0,        1'b0});
        tbl.push_back('{1, 3'b010, 1'b0, 32'h0C, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{1, 3'b100, 1'b0, 32'h0C, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{1, 3'b001, 1'b0, 32'h0C, 32'h0,        32'hA5,       1'b0});
        tbl.push_back('{1, 3'b001, 1'b1, 32'h40, 32'h55,       32'h0,        SLVERR_EN});
        tbl.push_back('{1, 3'b001, 1'b0, 32'h40, 32'h0,        32'h0,        SLVERR_EN});
        tbl.push_back('{1, 3'b001, 1'b0, 32'h00, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{1, 3'b011, 1'b1, 32'h10, 32'h66,       32'h0,        SLVERR_EN});
        tbl.push_back('{1, 3'b001, 1'b0, 32'h10, 32'h0,        SLVERR_EN ? 32'h0 : 32'h66, 1'b0});
        tbl.push_back('{1, 3'b010, 1'b0, 32'h10, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{2, 3'b100, 1'b1, 32'h3C, 32'h12345678, 32'h0,        1'b0});
        tbl.push_back('{2, 3'b100, 1'b0, 32'h3C, 32'h0,        32'h12345678, 1'b0});

        foreach (tbl[i]) begin
            model_apply(tbl[i].k, tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, exp_rd, exp_e);
            xfer(tbl[i].k, tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, rd, e, n);
            check($sformatf("vec%0d_prdata", i), rd, tbl[i].rd);
            check($sformatf("vec%0d_pslverr", i), 32'(e), 32'(tbl[i].e));
            check($sformatf("vec%0d_latency", i), 32'(n), 32'(wait_of(tbl[i].k) + 1));
        end
        bus_idle();

        // Abort a write on bank 2 (WAIT_CYCLES=3) in its second ACCESS cycle.
        model_apply(2, 3'b001, 1'b1, 32'h14, 32'h99, exp_rd, exp_e);
        xfer(2, 3'b001, 1'b1, 32'h14, 32'h99, rd, e, n);
        check("abort_pre_lat", 32'(n), 32'd4);
        @(negedge clk);
        drive_idle();
        psel[2] = 3'b001; wr = 1'b1; addr = 32'h14; wdata = 32'h77;
        @(negedge clk); en = 1'b1;
        @(negedge clk); check("abort_c1_pready", 32'(pready[2]), 32'd0);
        @(negedge clk); check("abort_c2_pready", 32'(pready[2]), 32'd0);
        drive_idle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_after_pready", 32'(pready[2]), 32'd0);
        end
        xfer(2, 3'b001, 1'b0, 32'h14, 32'h0, rd, e, n);
        check("abort_readback", rd, 32'h99);
        bus_idle();

        // Random transfers checked against the reference model.
        for (int i = 0; i < 80; i++) begin
            int            k  = $urandom_range(0, 2);
            logic [NS-1:0] s  = NS'($urandom_range(1, 7));
            logic          w  = 1'($urandom_range(0, 1));
            logic [31:0]   a  = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
            logic [31:0]   d  = $urandom;
            model_apply(k, s, w, a, d, exp_rd, exp_e);
            xfer(k, s, w, a, d, rd, e, n);
            check("rnd_prdata", rd, exp_rd);
            check("rnd_pslverr", 32'(e), 32'(exp_e));
            check("rnd_latency", 32'(n), 32'(wait_of(k) + 1));
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
